// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor sequencer.
// Contents:
//   state_t  - sequencer state (IDLE, SHIFT, DONE)
//   MODE_ADD - mode encoding for addition
//   MODE_SUB - mode encoding for subtraction (a - b)
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_seq_if.sv
// Bundle of request/result and half-cell signals for serial_addsub_seq.
// Signals:
//   start, mode, a_in, b_in        - operation request (sampled with start)
//   busy, done, result, carry_out  - status and final result
//   cell_a, cell_b, cell_mode      - bit pair and mode sent to the half cell
//   cell_sd, cell_cb               - combinational return from the half cell
// Modports:
//   slave  - the sequencer side
//   master - the parent side (requester plus the half cell)
interface serial_addsub_seq_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             cell_a;
   logic             cell_b;
   logic             cell_mode;
   logic             cell_sd;
   logic             cell_cb;

   modport slave (
      input  start, mode, a_in, b_in, cell_sd, cell_cb,
      output busy, done, result, carry_out, cell_a, cell_b, cell_mode
   );

   modport master (
      output start, mode, a_in, b_in, cell_sd, cell_cb,
      input  busy, done, result, carry_out, cell_a, cell_b, cell_mode
   );

endinterface

// File: rtl/serial_addsub_merge.sv
// Combines the half cell's outputs with the registered carry/borrow to form
// one full-adder / full-subtractor result bit and the next carry/borrow.
// Ports:
//   mode       in  - MODE_ADD or MODE_SUB
//   cell_sd    in  - half cell SumDiff
//   cell_cb    in  - half cell CarryBorrow
//   carry      in  - carry/borrow coming from the previous bit
//   sum_bit    out - final sum/difference bit
//   next_carry out - carry/borrow for the next bit
module serial_addsub_merge
   import serial_addsub_pkg::*;
(
   input  logic mode,
   input  logic cell_sd,
   input  logic cell_cb,
   input  logic carry,
   output logic sum_bit,
   output logic next_carry
);

   // The second half stage folds the incoming carry/borrow into the cell's
   // partial result; only one of the two stages can ever generate, so an OR
   // merges them.
   assign sum_bit    = cell_sd ^ carry;
   assign next_carry = (mode == MODE_SUB) ? (cell_cb | (~cell_sd & carry))
                                          : (cell_cb | ( cell_sd & carry));

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial WIDTH-bit adder/subtractor sequencer. Latches two operands and
// a mode, feeds one bit pair per cycle (LSB first) to an external half
// adder/subtractor cell, merges its outputs with a registered carry/borrow
// and reports the WIDTH-bit result plus final carry/borrow with a one-cycle
// done pulse, WIDTH cycles after start is accepted.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - serial_addsub_seq_if.slave (request, status, result, cell link)
module serial_addsub_seq
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   serial_addsub_seq_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   acc;
   logic [CNT_W-1:0]   bit_cnt;
   logic               mode_q;
   logic               carry_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;
   logic               carry_out_q;
   logic               sum_bit;
   logic               next_carry;

   serial_addsub_merge u_merge (
      .mode       (mode_q),
      .cell_sd    (bus.cell_sd),
      .cell_cb    (bus.cell_cb),
      .carry      (carry_q),
      .sum_bit    (sum_bit),
      .next_carry (next_carry)
   );

   // The cell only sees live operand bits while shifting; outside SHIFT it
   // is held quiet.
   assign bus.cell_a    = (state == SHIFT) ? a_sr[0] : 1'b0;
   assign bus.cell_b    = (state == SHIFT) ? b_sr[0] : 1'b0;
   assign bus.cell_mode = (state == SHIFT) ? mode_q  : 1'b0;

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;

   // Sequencer: accepts a start in IDLE or DONE, spends WIDTH cycles in
   // SHIFT processing one bit per cycle, then pulses done for one cycle.
   // The last bit goes straight into result rather than through acc, so
   // result is complete on the same edge that enters DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         acc         <= '0;
         bit_cnt     <= '0;
         mode_q      <= MODE_ADD;
         carry_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sr    <= bus.a_in;
                  b_sr    <= bus.b_in;
                  mode_q  <= bus.mode;
                  carry_q <= 1'b0;
                  bit_cnt <= '0;
                  busy_q  <= 1'b1;
                  state   <= SHIFT;
               end else begin
                  state   <= IDLE;
               end
            end
            SHIFT: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               acc     <= {sum_bit, acc[WIDTH-1:1]};
               carry_q <= next_carry;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  result_q    <= {sum_bit, acc[WIDTH-1:1]};
                  carry_out_q <= next_carry;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state       <= DONE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Self-checking bench for serial_addsub_seq with a behavioural half
// adder/subtractor cell and a plain-arithmetic reference model.
module tb_serial_addsub_seq;
   import serial_addsub_pkg::*;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   serial_addsub_seq_if #(.WIDTH(W)) bus ();

   serial_addsub_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Behavioural half adder / half subtractor cell sitting beside the DUT.
   assign bus.cell_sd = bus.cell_a ^ bus.cell_b;
   assign bus.cell_cb = bus.cell_mode ? (~bus.cell_a & bus.cell_b)
                                      : ( bus.cell_a & bus.cell_b);

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: whole-word arithmetic, carry = overflow, borrow = a < b.
   function automatic void ref_model(input logic m, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic c);
      int s;
      if (m == MODE_ADD) begin
         s = int'(a) + int'(b);
         r = W'(s % (1 << W));
         c = (s >= (1 << W));
      end else begin
         s = int'(a) - int'(b) + (1 << W);
         r = W'(s % (1 << W));
         c = (a < b);
      end
   endfunction

   // Issues one operation and waits for done; lat = edges from accept to done.
   task automatic run_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output int lat);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mode = m; bus.a_in = a; bus.b_in = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.mode  = 1'($urandom);
      bus.a_in  = W'($urandom);
      bus.b_in  = W'($urandom);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (bus.done) break;
         @(posedge clk);
         lat++;
      end
      r = bus.result;
      c = bus.carry_out;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.done, bus.carry_out} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL reset_status: busy/done/carry got %b want 000",
                  {bus.busy, bus.done, bus.carry_out});
      end
      tests_run++;
      if (bus.result !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_result: got %h want 00", bus.result);
      end
      tests_run++;
      if ({bus.cell_a, bus.cell_b, bus.cell_mode} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL reset_cell: got %b want 000",
                  {bus.cell_a, bus.cell_b, bus.cell_mode});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0] av[4] = '{8'h3C, 8'hFF, 8'h10, 8'h01};
      logic [W-1:0] bv[4] = '{8'h5A, 8'h01, 8'h01, 8'h02};
      logic         mv[4] = '{MODE_ADD, MODE_ADD, MODE_SUB, MODE_SUB};
      logic [W-1:0] r, er;
      logic         c, ec;
      int           lat;
      for (int i = 0; i < 4; i++) begin
         ref_model(mv[i], av[i], bv[i], er, ec);
         run_op(mv[i], av[i], bv[i], r, c, lat);
         tests_run++;
         if (lat !== W) begin
            tests_failed++;
            $display("[TB] FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W);
         end
         tests_run++;
         if ({c, r} !== {ec, er}) begin
            tests_failed++;
            $display("[TB] FAIL directed_result[%0d]: got c=%b r=%h want c=%b r=%h",
                     i, c, r, ec, er);
         end
      end
   endtask

   task automatic test_hold_and_cell();
      logic [W-1:0] r, prev, er;
      logic         c, ec;
      int           lat, j;
      run_op(MODE_ADD, 8'h3C, 8'h5A, prev, c, lat);
      ref_model(MODE_SUB, 8'h01, 8'h02, er, ec);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mode = MODE_SUB; bus.a_in = 8'h01; bus.b_in = 8'h02;
      @(posedge clk); #1;
      bus.start = 1'b0;
      j = 0;
      while (j < 40) begin
         @(negedge clk);
         if (bus.done) break;
         tests_run++;
         if ({bus.busy, bus.cell_mode, bus.result} !== {1'b1, MODE_SUB, 8'h96}) begin
            tests_failed++;
            $display("[TB] FAIL hold_busy_cell[%0d]: busy=%b mode=%b result=%h want 1 1 96",
                     j, bus.busy, bus.cell_mode, bus.result);
         end
         @(posedge clk);
         j++;
      end
      r = bus.result;
      c = bus.carry_out;
      tests_run++;
      if ({j, c, r} !== {W, ec, er}) begin
         tests_failed++;
         $display("[TB] FAIL hold_final: got lat=%0d c=%b r=%h want lat=%0d c=%b r=%h",
                  j, c, r, W, ec, er);
      end
      tests_run++;
      if (prev !== 8'h96) begin
         tests_failed++;
         $display("[TB] FAIL hold_prev: got %h want 96", prev);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, r, er;
      logic         m, c, ec;
      int           lat;
      for (int i = 0; i < 20; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         m = 1'($urandom);
         ref_model(m, a, b, er, ec);
         run_op(m, a, b, r, c, lat);
         tests_run++;
         if ({lat, c, r} !== {W, ec, er}) begin
            tests_failed++;
            $display("[TB] FAIL random[%0d] m=%b a=%h b=%h: got lat=%0d c=%b r=%h want lat=%0d c=%b r=%h",
                     i, m, a, b, lat, c, r, W, ec, er);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] er;
      logic         ec;
      int           j;
      ref_model(MODE_ADD, 8'hA5, 8'h6B, er, ec);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mode = MODE_ADD; bus.a_in = 8'hA5; bus.b_in = 8'h6B;
      @(posedge clk); #1;
      bus.start = 1'b0;
      j = 0;
      while (j < 40) begin
         @(negedge clk);
         if (bus.done) break;
         @(posedge clk);
         j++;
         #1;
         if (j == 2) begin
            bus.start = 1'b1; bus.mode = MODE_SUB; bus.a_in = 8'h12; bus.b_in = 8'hEE;
         end
         if (j == 3) bus.start = 1'b0;
      end
      tests_run++;
      if ({j, bus.carry_out, bus.result} !== {W, ec, er}) begin
         tests_failed++;
         $display("[TB] FAIL ignore_start: got lat=%0d c=%b r=%h want lat=%0d c=%b r=%h",
                  j, bus.carry_out, bus.result, W, ec, er);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] r, er;
      logic         c, ec;
      int           lat, seen_done;
      run_op(MODE_ADD, 8'h11, 8'h22, r, c, lat);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mode = MODE_ADD; bus.a_in = 8'hF0; bus.b_in = 8'h33;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({bus.busy, bus.done, bus.carry_out, bus.result, bus.cell_a, bus.cell_b, bus.cell_mode}
          !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_outputs: busy=%b done=%b c=%b r=%h cell=%b%b%b want all 0",
                  bus.busy, bus.done, bus.carry_out, bus.result,
                  bus.cell_a, bus.cell_b, bus.cell_mode);
      end
      seen_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen_done++;
      end
      tests_run++;
      if (seen_done !== 0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_quiet: got %0d active cycles want 0", seen_done);
      end
      ref_model(MODE_SUB, 8'h80, 8'h7F, er, ec);
      run_op(MODE_SUB, 8'h80, 8'h7F, r, c, lat);
      tests_run++;
      if ({lat, c, r} !== {W, ec, er}) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_recover: got lat=%0d c=%b r=%h want lat=%0d c=%b r=%h",
                  lat, c, r, W, ec, er);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] r1, r2, er1, er2;
      logic         c1, c2, ec1, ec2;
      int           j, d1, d2;
      ref_model(MODE_ADD, 8'h01, 8'h01, er1, ec1);
      ref_model(MODE_SUB, 8'h05, 8'h03, er2, ec2);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mode = MODE_ADD; bus.a_in = 8'h01; bus.b_in = 8'h01;
      @(posedge clk); #1;
      bus.mode = MODE_SUB; bus.a_in = 8'h05; bus.b_in = 8'h03;
      j = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0; c1 = 1'b0; c2 = 1'b0;
      while (j < 40 && d2 < 0) begin
         @(negedge clk);
         if (bus.done) begin
            if (d1 < 0) begin
               d1 = j; r1 = bus.result; c1 = bus.carry_out;
            end else begin
               d2 = j; r2 = bus.result; c2 = bus.carry_out;
            end
         end
         @(posedge clk);
         j++;
         if (d1 >= 0 && j == d1 + 1) begin
            #1 bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      tests_run++;
      if (d1 !== W) begin
         tests_failed++;
         $display("[TB] FAIL b2b_first_latency: got %0d want %0d", d1, W);
      end
      tests_run++;
      if (d2 - d1 !== W + 1) begin
         tests_failed++;
         $display("[TB] FAIL b2b_spacing: got %0d want %0d", d2 - d1, W + 1);
      end
      tests_run++;
      if ({c1, r1, c2, r2} !== {ec1, er1, ec2, er2}) begin
         tests_failed++;
         $display("[TB] FAIL b2b_results: got %b/%h %b/%h want %b/%h %b/%h",
                  c1, r1, c2, r2, ec1, er1, ec2, er2);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.mode     = MODE_ADD;
      bus.a_in     = '0;
      bus.b_in     = '0;
      test_reset();
      test_directed();
      test_hold_and_cell();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
